comp_divide_seq: RTL and testbench
==================================

Name: comp_divide_seq

Overview:
- Sequential single-precision complex divider: result = a / b, computed as a·conj(b) · (1/|b|²).
- Performs the inverse operation of comp_multiply and sits beside it in the IPU datapath.
- Time-multiplexes one comp_multiply instance and one fpu_add instance (both double=0) under an FSM.
- The reciprocal is computed by Newton-Raphson iteration.

Parameters:
- NR_ITERS, 3, number of Newton-Raphson refinement iterations (legal range 1..4).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block idle and able to accept operands.
- a  input  64  dividend, packed {re[63:32], im[31:0]}, IEEE754 single.
- b  input  64  divisor, same packing.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- result  output  64  quotient, packed {re, im}.
- div_by_zero  output  1  qualified by out_valid; set when b.re and b.im are both ±0.

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, div_by_zero=0, state=IDLE. All internal registers are cleared.
- Reset mid-operation aborts the operation. The next cycle is IDLE with no stale out_valid.
- Accept: in_valid && in_ready captures a and b. in_ready is low from the next cycle until the result is accepted.
- FSM states, one registered step per cycle:
  - IDLE: on accept → MAG.
  - MAG: D = re(comp_multiply(b, conj(b))), where conj flips bit 31. If D exponent and mantissa are all zero → DONE with div_by_zero=1 and result={32'h7FC00000, 32'h7FC00000}. Otherwise → SEED.
  - SEED: x = NR_MAGIC − D bits (32-bit integer subtract) → NR_MUL.
  - NR_MUL: t = D·x, using comp_multiply with imaginary parts 0 → NR_SUB.
  - NR_SUB: s = fpu_add(TWO, t with sign flipped) → NR_UPD.
  - NR_UPD: x = x·s. Increment iteration counter. If count == NR_ITERS → NUM, else → NR_MUL.
  - NUM: N = comp_multiply(a, conj(b)) → SCALE.
  - SCALE: result = comp_multiply(N, {x, 32'h0}) → DONE.
  - DONE: out_valid=1. On out_ready → IDLE, and in_ready goes high the same edge.
- Latency: out_valid rises 5+3·NR_ITERS cycles after the accept edge (14 at default).
  - Divide-by-zero path: out_valid rises 2 cycles after the accept edge.
- Backpressure: while out_valid && !out_ready, result and div_by_zero are held stable. No new operand is accepted.
- in_valid while busy is ignored; the operands are not queued.
- Zero dividend: the normal path runs and yields ±0 components.
- Operands that are NaN/Inf propagate through the sub-units. No special handling is required beyond div_by_zero.
- Accuracy: each component within 2 ULP of the correctly rounded quotient for normal operands, with NR_ITERS ≥ 3.
- Only the single-precision lane is used. No double support.

Decomposition:
- Shared package ipu_pkg holds:
  - constants SP_ONE=32'h3F800000, SP_TWO=32'h40000000, NR_MAGIC=32'h7EF311C7, SP_QNAN=32'h7FC00000;
  - the state enum for this FSM;
  - helper functions cplx_conj(64-bit) and cplx_re/cplx_im field extractors.
- Sub-modules: reuse the existing comp_multiply #(.double(0)) and fpu_add #(.double(0)) instances, one each, with operand muxes driven by the state.
- No new sub-module is warranted.

Test Plan:
- a=64'h3DCCCCCD3DCCCCCD (0.1+0.1i), b=same → result within 2 ULP of 64'h3F80000000000000 (1+0i); out_valid exactly 14 cycles after accept.
- a=64'h3F80000040000000 (1+2i), b=64'h3F8000003F800000 (1+1i) → result ≈ 64'h3FC000003F000000 (1.5+0.5i); div_by_zero=0.
- a=64'h4080000040C00000 (4+6i), b=64'h4000000000000000 (2+0i) → result ≈ 64'h4000000040400000 (2+3i).
- b=64'h0000000080000000 (+0, −0i), any a → out_valid 2 cycles after accept; div_by_zero=1; result=64'h7FC000007FC00000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → result stable and in_ready=0 throughout. Pulse out_ready → in_ready=1 next cycle, and back-to-back ops are correct.
- Assert rst for 1 cycle during NR_SUB → next cycle out_valid=0, in_ready=1. The following op (1+2i)/(1+1i) still yields ≈1.5+0.5i.

Source files
------------

// File: rtl/ipu_pkg.sv
// Shared IPU definitions: single-precision constants, the divider FSM states,
// complex-field helpers and the flush-to-zero SP multiply/add used by the datapath units.
package ipu_pkg;

  localparam logic [31:0] SP_ONE   = 32'h3F80_0000;
  localparam logic [31:0] SP_TWO   = 32'h4000_0000;
  localparam logic [31:0] NR_MAGIC = 32'h7EF3_11C7;
  localparam logic [31:0] SP_QNAN  = 32'h7FC0_0000;

  typedef enum logic [3:0] {
    ST_IDLE, ST_MAG, ST_SEED, ST_NR_MUL, ST_NR_SUB, ST_NR_UPD, ST_NUM, ST_SCALE, ST_DONE
  } div_state_t;

  function automatic logic [63:0] cplx_conj(input logic [63:0] z);
    return {z[63:32], ~z[31], z[30:0]};
  endfunction

  function automatic logic [31:0] cplx_re(input logic [63:0] z);
    return z[63:32];
  endfunction

  function automatic logic [31:0] cplx_im(input logic [63:0] z);
    return z[31:0];
  endfunction

  // sig carries the hidden bit at [23]; subnormal results flush to signed zero.
  function automatic logic [31:0] sp_round_pack(input logic s, input logic signed [9:0] e,
                                                input logic [23:0] sig, input logic g,
                                                input logic st);
    logic              up;
    logic [24:0]       m;
    logic signed [9:0] ef;
    logic [22:0]       frac;
    up   = g & (st | sig[0]);
    m    = {1'b0, sig} + {24'd0, up};
    ef   = e;
    frac = m[22:0];
    if (m[24]) begin
      ef   = e + 10'sd1;
      frac = 23'd0;
    end
    if (ef >= 10'sd255) return {s, 8'hFF, 23'd0};
    if (ef <= 10'sd0) return {s, 31'd0};
    return {s, ef[7:0], frac};
  endfunction

  function automatic logic [31:0] sp_mul(input logic [31:0] a, input logic [31:0] b);
    logic              s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       prod;
    logic signed [9:0] e;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return SP_QNAN;
    if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {s, 31'd0};
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) e = e + 10'sd1;
    else          prod = prod << 1;
    return sp_round_pack(s, e, prod[47:24], prod[23], |prod[22:0]);
  endfunction

  // Three low bits are guard/round/sticky so alignment and cancellation round exactly.
  function automatic logic [31:0] sp_add(input logic [31:0] a, input logic [31:0] b);
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, found;
    logic [31:0]       big, sml;
    logic [7:0]        ediff, sh;
    logic [50:0]       wide;
    logic [26:0]       xl, xs, v;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] e;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    if (a_nan || b_nan) return SP_QNAN;
    if (a_inf && b_inf) return (a[31] == b[31]) ? a : SP_QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
    if (a_zero) return b;
    if (b_zero) return a;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    ediff = big[30:23] - sml[30:23];
    sh    = (ediff > 8'd31) ? 8'd31 : ediff;
    xl    = {1'b1, big[22:0], 3'b000};
    wide  = {1'b1, sml[22:0], 27'd0} >> sh;
    xs    = {wide[50:25], wide[24] | (|wide[23:0])};
    e     = $signed({2'b00, big[30:23]});
    if (big[31] == sml[31]) begin
      sum = {1'b0, xl} + {1'b0, xs};
      if (sum[27]) begin
        v = {sum[27:2], sum[1] | sum[0]};
        e = e + 10'sd1;
      end else begin
        v = sum[26:0];
      end
    end else begin
      v = xl - xs;
      if (v == 27'd0) return 32'd0;
      lz    = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && v[i]) begin
          lz    = 5'(26 - i);
          found = 1'b1;
        end
      end
      v = v << lz;
      e = e - $signed({5'd0, lz});
    end
    return sp_round_pack(big[31], e, v[26:3], v[2], |v[1:0]);
  endfunction

endpackage

// File: rtl/comp_multiply.sv
// Combinational complex multiply {re,im} x {re,im}; single-precision lane (double=0) only.
module comp_multiply
  import ipu_pkg::*;
#(
  parameter int double = 0
) (
  input  logic [((double != 0) ? 128 : 64)-1:0] i_a,
  input  logic [((double != 0) ? 128 : 64)-1:0] i_b,
  output logic [((double != 0) ? 128 : 64)-1:0] o_p
);

  logic [31:0] w_rr, w_ii, w_ri, w_ir;

  assign w_rr = sp_mul(i_a[63:32], i_b[63:32]);
  assign w_ii = sp_mul(i_a[31:0],  i_b[31:0]);
  assign w_ri = sp_mul(i_a[63:32], i_b[31:0]);
  assign w_ir = sp_mul(i_a[31:0],  i_b[63:32]);
  assign o_p  = {sp_add(w_rr, {~w_ii[31], w_ii[30:0]}), sp_add(w_ri, w_ir)};

endmodule

// File: rtl/fpu_add.sv
// Combinational floating-point adder; only the single-precision lane (double=0) is built.
module fpu_add
  import ipu_pkg::*;
#(
  parameter int double = 0
) (
  input  logic [((double != 0) ? 64 : 32)-1:0] i_a,
  input  logic [((double != 0) ? 64 : 32)-1:0] i_b,
  output logic [((double != 0) ? 64 : 32)-1:0] o_y
);

  assign o_y = sp_add(i_a, i_b);

endmodule

// File: rtl/comp_divide_seq.sv
// Sequential complex divider a/b = a*conj(b) * (1/|b|^2), sharing one complex multiplier
// and one adder across FSM steps; 1/|b|^2 comes from Newton-Raphson on a bit-trick seed.
module comp_divide_seq
  import ipu_pkg::*;
#(
  parameter int NR_ITERS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        div_by_zero
);

  div_state_t  r_state;
  logic [63:0] r_a, r_b, r_n, r_result;
  logic [31:0] r_d, r_x, r_t, r_s;
  logic [2:0]  r_iter;
  logic        r_in_ready, r_out_valid, r_dbz;
  logic [63:0] w_mul_a, w_mul_b, w_mul_p;
  logic [31:0] w_add_y;
  logic        w_d_zero;

  // Real-only operands ({x, 0}) reuse the complex multiplier as a scalar multiply.
  always_comb begin
    w_mul_a = 64'd0;
    w_mul_b = 64'd0;
    case (r_state)
      ST_MAG: begin
        w_mul_a = r_b;
        w_mul_b = cplx_conj(r_b);
      end
      ST_NR_MUL: begin
        w_mul_a = {r_d, 32'd0};
        w_mul_b = {r_x, 32'd0};
      end
      ST_NR_UPD: begin
        w_mul_a = {r_x, 32'd0};
        w_mul_b = {r_s, 32'd0};
      end
      ST_NUM: begin
        w_mul_a = r_a;
        w_mul_b = cplx_conj(r_b);
      end
      ST_SCALE: begin
        w_mul_a = r_n;
        w_mul_b = {r_x, 32'd0};
      end
      default: ;
    endcase
  end

  comp_multiply #(.double(0)) u_cmul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_mul_p)
  );

  fpu_add #(.double(0)) u_fadd (
    .i_a (SP_TWO),
    .i_b ({~r_t[31], r_t[30:0]}),
    .o_y (w_add_y)
  );

  assign w_d_zero = (w_mul_p[62:32] == 31'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= 64'd0;
      r_b         <= 64'd0;
      r_n         <= 64'd0;
      r_result    <= 64'd0;
      r_d         <= 32'd0;
      r_x         <= 32'd0;
      r_t         <= 32'd0;
      r_s         <= 32'd0;
      r_iter      <= 3'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
            r_b        <= b;
            r_iter     <= 3'd0;
            r_in_ready <= 1'b0;
            r_state    <= ST_MAG;
          end
        end
        ST_MAG: begin
          r_d <= cplx_re(w_mul_p);
          if (w_d_zero) begin
            r_result <= {SP_QNAN, SP_QNAN};
            r_dbz    <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_state  <= ST_SEED;
          end
        end
        ST_SEED: begin
          r_x     <= NR_MAGIC - r_d;
          r_state <= ST_NR_MUL;
        end
        ST_NR_MUL: begin
          r_t     <= cplx_re(w_mul_p);
          r_state <= ST_NR_SUB;
        end
        ST_NR_SUB: begin
          r_s     <= w_add_y;
          r_state <= ST_NR_UPD;
        end
        ST_NR_UPD: begin
          r_x    <= cplx_re(w_mul_p);
          r_iter <= r_iter + 3'd1;
          if (r_iter == 3'(NR_ITERS - 1)) r_state <= ST_NUM;
          else                            r_state <= ST_NR_MUL;
        end
        ST_NUM: begin
          r_n     <= w_mul_p;
          r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          r_result <= w_mul_p;
          r_dbz    <= 1'b0;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_comp_divide_seq.sv
// Bench for comp_divide_seq: directed and random divides checked against a real-valued
// complex-division model, plus latency, handshake, backpressure and reset-abort behaviour.
module tb_comp_divide_seq;

  localparam int NR = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  comp_divide_seq #(.NR_ITERS(NR)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input real got, input real exp, input real tol);
    n_checks++;
    if (!((got - exp <= tol) && (exp - got <= tol))) begin
      n_fail++;
      $display("FAIL %s: got %.9g, expected %.9g (tol %.3g)", tag, got, exp, tol);
    end
  endtask

  function automatic real sp2r(input logic [31:0] f);
    real v;
    int  e;
    if (f[30:23] == 8'hFF) return 1.0e300;
    if (f[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return f[31] ? -v : v;
  endfunction

  function automatic real ulp_of(input real x);
    real ax, p;
    ax = (x < 0.0) ? -x : x;
    if (ax == 0.0) return 0.0;
    p = 1.0;
    for (int i = 0; i < 300 && ax >= 2.0 * p; i++) p = p * 2.0;
    for (int i = 0; i < 300 && ax < p; i++) p = p / 2.0;
    return p / 8388608.0;
  endfunction

  function automatic logic [31:0] rnd_sp();
    logic [7:0] e;
    e = 8'($urandom_range(124, 130));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic run_op(input string name, input logic [63:0] op_a, input logic [63:0] op_b,
                        input int hold, input bit tight);
    real ar, ai, br, bi, den, qr, qi, qmag, tr, ti;
    bit  exp_dz;
    int  cnt, exp_lat;
    ar = sp2r(op_a[63:32]);
    ai = sp2r(op_a[31:0]);
    br = sp2r(op_b[63:32]);
    bi = sp2r(op_b[31:0]);
    exp_dz  = (op_b[62:32] == 31'd0) && (op_b[30:0] == 31'd0);
    exp_lat = exp_dz ? 2 : 5 + 3 * NR;
    qr = 0.0; qi = 0.0; tr = 0.0; ti = 0.0;
    if (!exp_dz) begin
      den  = br * br + bi * bi;
      qr   = (ar * br + ai * bi) / den;
      qi   = (ai * br - ar * bi) / den;
      qmag = $sqrt(qr * qr + qi * qi);
      if (tight) begin
        tr = 2.0 * ulp_of(qr);
        ti = 2.0 * ulp_of(qi);
        if (tr < qmag / 8388608.0) tr = qmag / 8388608.0;
        if (ti < qmag / 8388608.0) ti = qmag / 8388608.0;
      end else begin
        tr = qmag / 1048576.0;
        ti = qmag / 1048576.0;
      end
    end

    @(negedge clk);
    check({name, " in_ready_idle"}, real'(in_ready), 1.0, 0.0);
    in_valid = 1'b1;
    a = op_a;
    b = op_b;
    @(posedge clk);
    #1;
    // Busy-time operands must be ignored.
    a = {rnd_sp(), rnd_sp()};
    b = {rnd_sp(), rnd_sp()};
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 2) in_valid = 1'b0;
    end while (!out_valid && cnt < 60);
    in_valid = 1'b0;

    check({name, " latency"}, real'(cnt), real'(exp_lat), 0.0);
    check({name, " in_ready_busy"}, real'(in_ready), 0.0, 0.0);
    for (int k = 0; k <= hold; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        check({name, " hold_valid"}, real'(out_valid), 1.0, 0.0);
        check({name, " hold_in_ready"}, real'(in_ready), 0.0, 0.0);
      end
      check({name, " dbz"}, real'(div_by_zero), exp_dz ? 1.0 : 0.0, 0.0);
      if (exp_dz) begin
        check({name, " re_bits"}, real'(result[63:32]), real'(32'h7FC0_0000), 0.0);
        check({name, " im_bits"}, real'(result[31:0]), real'(32'h7FC0_0000), 0.0);
      end else begin
        check({name, " re"}, sp2r(result[63:32]), qr, tr);
        check({name, " im"}, sp2r(result[31:0]), qi, ti);
      end
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({name, " valid_drop"}, real'(out_valid), 0.0, 0.0);
    check({name, " ready_back"}, real'(in_ready), 1.0, 0.0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, ia, rb, ib;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 64'd0;
    b         = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", real'(in_ready), 1.0, 0.0);
    check("rst out_valid", real'(out_valid), 0.0, 0.0);
    check("rst dbz", real'(div_by_zero), 0.0, 0.0);
    check("rst result_re", real'(result[63:32]), 0.0, 0.0);
    check("rst result_im", real'(result[31:0]), 0.0, 0.0);
    rst = 1'b0;

    run_op("unit", 64'h3DCCCCCD3DCCCCCD, 64'h3DCCCCCD3DCCCCCD, 0, 1'b1);
    run_op("1p2i_1p1i", 64'h3F80000040000000, 64'h3F8000003F800000, 0, 1'b1);
    run_op("4p6i_2", 64'h4080000040C00000, 64'h4000000000000000, 0, 1'b1);
    run_op("div0", 64'h3F80000040000000, 64'h0000000080000000, 0, 1'b1);
    run_op("bp", 64'h3F80000040000000, 64'h3F8000003F800000, 5, 1'b1);
    run_op("b2b", 64'h4080000040C00000, 64'h4000000000000000, 0, 1'b1);
    run_op("zero_a", 64'h0000000080000000, 64'h3F8000003F800000, 0, 1'b1);

    // Abort in NR_SUB: accept edge, then SEED, NR_MUL, NR_SUB.
    @(negedge clk);
    in_valid = 1'b1;
    a = 64'h3F80000040000000;
    b = 64'h3F8000003F800000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort out_valid", real'(out_valid), 0.0, 0.0);
    check("abort in_ready", real'(in_ready), 1.0, 0.0);
    check("abort result_re", real'(result[63:32]), 0.0, 0.0);
    run_op("after_abort", 64'h3F80000040000000, 64'h3F8000003F800000, 0, 1'b1);

    for (int n = 0; n < 24; n++) begin
      ra = rnd_sp();
      ia = rnd_sp();
      rb = rnd_sp();
      ib = rnd_sp();
      if ($urandom_range(0, 9) == 0) begin
        ra = {ra[31], 31'd0};
        ia = {ia[31], 31'd0};
      end
      if ($urandom_range(0, 7) == 0) begin
        rb = {rb[31], 31'd0};
        ib = {ib[31], 31'd0};
      end
      run_op($sformatf("rnd%0d", n), {ra, ia}, {rb, ib}, $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
